seq_detector_param: RTL and testbench

Parametrised, runtime-programmable serial bit-sequence detector. It is the successor to the fixed 4-bit Mealy detector for "1101".
- Pattern value and length (2..MAX_LEN) are loaded through a config port.
- Overlapping and non-overlapping detection are both supported.
- Outputs: a Mealy match pulse, a registered Moore-style pulse and a saturating match counter.
- Sits on a serial data stream that is qualified by a valid strobe.

---
 rtl/seq_detector_pkg.sv | 18 +
 rtl/seq_detector_param_if.sv | 31 +++
 rtl/sat_counter.sv | 27 ++
 rtl/seq_detector_param.sv | 86 ++++++++
 tb/tb_seq_detector_param.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detector_pkg.sv
// Shared helpers for the programmable serial sequence detector.
// Latency: n/a (compile-time and combinational helpers only).
// Backpressure: n/a.
package seq_detector_pkg;

  // Width needed to hold a pattern length in the range 0..max_len.
  function automatic int lw_of(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Programmed lengths outside 2..max_len are pulled to the nearest legal value.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 2)       return 2;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Data, config and result bundle of the sequence detector.
// Latency: n/a (wiring only).
// Backpressure: none; the stream is qualified by in_valid only.
interface seq_detector_param_if
  import seq_detector_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LW      = lw_of(MAX_LEN)
);
  logic               in_valid;
  logic               i;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               q;
  logic               q_reg;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output in_valid, i, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  q, q_reg, match_cnt
  );

  modport slave (
    input  in_valid, i, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output q, q_reg, match_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects clr/inc one cycle later.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] r_cnt;

  // Clear wins over increment; increment stops at the maximum value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-sequence detector (overlap / non-overlap).
// Latency: q same cycle as the last pattern bit; q_reg and match_cnt +1 cycle.
// Backpressure: none; gaps on in_valid hold state, a config write drops that cycle's bit.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int               MAX_LEN = 8,
  parameter int               LEN     = 4,
  parameter logic [MAX_LEN-1:0] PATTERN = 8'b0000_1101,
  parameter logic             OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  parameter int               LW      = lw_of(MAX_LEN)
) (
  input logic clk,
  input logic rst,
  seq_detector_param_if.slave bus
);
  localparam int FW = $clog2(MAX_LEN);

  logic [MAX_LEN-2:0] r_hist;
  logic [FW-1:0]      r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_len;
  logic               r_ovl;
  logic               r_q_reg;

  logic [MAX_LEN-1:0] w_win;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_fill_ok;
  logic               w_match;
  logic               w_accept;
  logic               w_q;

  // Window is the history plus the bit on the wire; only the low len_r bits count.
  always_comb begin
    w_win  = {r_hist, bus.i};
    w_mask = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      w_mask[k] = (k < int'(r_len));
    end
    w_fill_ok = (int'(r_fill) + 1) >= int'(r_len);
    w_match   = ((w_win ^ r_pat) & w_mask) == '0;
    w_accept  = bus.in_valid & ~bus.cfg_we;
    w_q       = rst & w_accept & w_fill_ok & w_match;
  end

  // History, fill level, programmed pattern and the registered match pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= PATTERN;
      r_len   <= LW'(LEN);
      r_ovl   <= OVERLAP;
      r_q_reg <= 1'b0;
    end else begin
      r_q_reg <= w_q;
      if (bus.cfg_we) begin
        r_pat  <= bus.cfg_pattern;
        r_len  <= LW'(clamp_len(int'(bus.cfg_len), MAX_LEN));
        r_ovl  <= bus.cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
      end else if (bus.in_valid) begin
        r_hist <= w_win[MAX_LEN-2:0];
        // Non-overlap mode restarts the search from scratch after a hit.
        if (w_q && !r_ovl) begin
          r_fill <= '0;
        end else if (r_fill != FW'(MAX_LEN - 1)) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cnt_clr),
    .inc (w_q),
    .cnt (bus.match_cnt)
  );

  assign bus.q     = w_q;
  assign bus.q_reg = r_q_reg;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios then random traffic vs a queue model.
// Two instances share stimulus: 8-bit counter and 2-bit (saturating) counter.
module tb_seq_detector_param;
  logic clk;
  logic rst_n;

  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) bus8 ();
  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

  assign bus2.in_valid    = bus8.in_valid;
  assign bus2.i           = bus8.i;
  assign bus2.cfg_we      = bus8.cfg_we;
  assign bus2.cfg_pattern = bus8.cfg_pattern;
  assign bus2.cfg_len     = bus8.cfg_len;
  assign bus2.cfg_overlap = bus8.cfg_overlap;
  assign bus2.cnt_clr     = bus8.cnt_clr;

  seq_detector_param #(.MAX_LEN(8), .LEN(4), .PATTERN(8'b0000_1101), .OVERLAP(1'b1), .CNT_W(8))
    u_dut8 (.clk(clk), .rst(rst_n), .bus(bus8.slave));
  seq_detector_param #(.MAX_LEN(8), .LEN(4), .PATTERN(8'b0000_1101), .OVERLAP(1'b1), .CNT_W(2))
    u_dut2 (.clk(clk), .rst(rst_n), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int seen_q = 0;

  // Reference model: plain queue of accepted bits (newest at back) since last restart.
  bit         m_hist[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_qreg;
  int         m_cnt8;
  int         m_cnt2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hist.delete();
    m_pat  = 8'b0000_1101;
    m_len  = 4;
    m_ovl  = 1'b1;
    m_qreg = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endfunction

  // Match if the last len-1 accepted bits followed by b spell the pattern (MSB first).
  function automatic bit model_q(input bit v, input bit b, input bit we);
    int n;
    n = m_hist.size();
    if (!v || we) return 1'b0;
    if (n < m_len - 1) return 1'b0;
    if (b != m_pat[0]) return 1'b0;
    for (int k = 1; k < m_len; k++) begin
      if (m_hist[n-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step(input bit v, input bit b, input bit we = 1'b0, input logic [7:0] pat = 8'h00,
                      input int len = 0, input bit ovl = 1'b0, input bit clr = 1'b0);
    bit eq;
    bus8.in_valid    = v;
    bus8.i           = b;
    bus8.cfg_we      = we;
    bus8.cfg_pattern = pat;
    bus8.cfg_len     = 4'(len);
    bus8.cfg_overlap = ovl;
    bus8.cnt_clr     = clr;
    @(negedge clk);
    eq = model_q(v, b, we);
    check_eq("q", 32'(bus8.q), 32'(eq));
    check_eq("q_w2", 32'(bus2.q), 32'(eq));
    check_eq("q_reg", 32'(bus8.q_reg), 32'(m_qreg));
    check_eq("cnt8", 32'(bus8.match_cnt), 32'(m_cnt8));
    check_eq("cnt2", 32'(bus2.match_cnt), 32'(m_cnt2));
    if (bus8.q === 1'b1) seen_q++;
    @(posedge clk);
    m_qreg = eq;
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (eq) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
    if (we) begin
      m_pat = pat;
      m_ovl = ovl;
      m_len = (len < 2) ? 2 : ((len > 8) ? 8 : len);
      m_hist.delete();
    end else if (v) begin
      m_hist.push_back(b);
      if (eq && !m_ovl) m_hist.delete();
      while (m_hist.size() > 7) void'(m_hist.pop_front());
    end
    #1;
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear at once.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_q", 32'(bus8.q), 32'd0);
    check_eq("rst_q_reg", 32'(bus8.q_reg), 32'd0);
    check_eq("rst_cnt8", 32'(bus8.match_cnt), 32'd0);
    check_eq("rst_cnt2", 32'(bus2.match_cnt), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus8.in_valid    = 1'b0;
    bus8.i           = 1'b0;
    bus8.cfg_we      = 1'b0;
    bus8.cfg_pattern = '0;
    bus8.cfg_len     = '0;
    bus8.cfg_overlap = 1'b0;
    bus8.cnt_clr     = 1'b0;
    model_reset();
    #3;
    check_eq("init_q_reg", 32'(bus8.q_reg), 32'd0);
    check_eq("init_cnt", 32'(bus8.match_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Default 1101 overlapping: hits on bits 4 and 7.
    seen_q = 0;
    send_bits(8'b0110_1101, 7);
    step(1'b0, 1'b0);
    check_eq("t1_hits", 32'(seen_q), 32'd2);
    check_eq("t1_cnt", 32'(bus8.match_cnt), 32'd2);

    // Non-overlapping 1101: only the first hit.
    pulse_reset();
    step(1'b0, 1'b0, 1'b1, 8'b0000_1101, 4, 1'b0);
    seen_q = 0;
    send_bits(8'b0110_1101, 7);
    step(1'b0, 1'b0);
    check_eq("t2_hits", 32'(seen_q), 32'd1);
    check_eq("t2_cnt", 32'(bus8.match_cnt), 32'd1);

    // Gaps of three idle cycles do not break a partial sequence.
    pulse_reset();
    seen_q = 0;
    for (int k = 3; k >= 0; k--) begin
      logic [3:0] p;
      p = 4'b1101;
      step(1'b1, p[k]);
      if (k != 0) repeat (3) step(1'b0, 1'b1);
    end
    step(1'b0, 1'b0);
    check_eq("t3_hits", 32'(seen_q), 32'd1);

    // 3-bit 010 overlapping, then length clamping low and high.
    step(1'b0, 1'b0, 1'b1, 8'b0000_0010, 3, 1'b1);
    seen_q = 0;
    send_bits(8'b0000_1010, 5);
    check_eq("t4_hits", 32'(seen_q), 32'd2);
    step(1'b0, 1'b0, 1'b1, 8'b0000_0010, 0, 1'b1);
    seen_q = 0;
    send_bits(8'b0000_1010, 4);
    check_eq("t4_len_lo", 32'(seen_q), 32'd2);
    step(1'b0, 1'b0, 1'b1, 8'b1011_0011, 15, 1'b1);
    seen_q = 0;
    send_bits(8'b1011_0011, 8);
    check_eq("t4_len_hi", 32'(seen_q), 32'd1);

    // Saturation of the 2-bit counter, then clear on a match cycle.
    pulse_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    send_bits(8'b0000_1101, 4);
    for (int r = 0; r < 4; r++) send_bits(8'b0000_0101, 3);
    step(1'b0, 1'b0);
    check_eq("t5_sat2", 32'(bus2.match_cnt), 32'd3);
    check_eq("t5_cnt8", 32'(bus8.match_cnt), 32'd5);
    send_bits(8'b0000_0110, 3);
    step(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_eq("t5_clr", 32'(bus8.match_cnt), 32'd0);

    // Reset mid-sequence kills the partial match; config beats a final bit.
    pulse_reset();
    seen_q = 0;
    send_bits(8'b0000_0110, 3);
    pulse_reset();
    step(1'b1, 1'b1);
    send_bits(8'b0000_0110, 3);
    step(1'b1, 1'b1, 1'b1, 8'b0000_1101, 4, 1'b1);
    step(1'b1, 1'b1);
    check_eq("t6_hits", 32'(seen_q), 32'd0);

    // Random traffic with occasional reconfiguration, clears and resets.
    for (int n = 0; n < 3000; n++) begin
      bit v, b, we, clr, ovl;
      int len;
      logic [7:0] pat;
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      we  = ($urandom_range(0, 40) == 0);
      clr = ($urandom_range(0, 60) == 0);
      ovl = 1'($urandom_range(0, 1));
      pat = 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(2, 4));
      if ($urandom_range(0, 500) == 0) pulse_reset();
      step(v, b, we, pat, len, ovl, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
